// File: rtl/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: data-memory model for CPU benches with byte lanes, wait states, range trap and TOHOST completion
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   d_mem_req/addr/wdata/wen        CPU data request, held stable until d_mem_ready
//   d_mem_rdata, d_mem_ready        read data and access-complete strobe
//   dbg_addr, dbg_rdata             side-effect-free combinational peek port
//   done, done_code                 sticky completion flag and first TOHOST write value
//   err_oob, wr_count               sticky out-of-range flag, saturating in-range write count
module tb_data_mem_ctrl #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] TOHOST_ADDR = 32'h0000_0FFC,
   parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        d_mem_req,
   input  logic [31:0] d_mem_addr,
   input  logic [31:0] d_mem_wdata,
   input  logic [3:0]  d_mem_wen,
   output logic [31:0] d_mem_rdata,
   output logic        d_mem_ready,
   input  logic [31:0] dbg_addr,
   output logic [31:0] dbg_rdata,
   output logic        done,
   output logic [31:0] done_code,
   output logic        err_oob,
   output logic [31:0] wr_count
);
   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
   typedef enum logic {S_IDLE, S_WAIT} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        run_q, done_q, err_q;
   logic [31:0] code_q, wc_q;
   logic [31:0] mem [DEPTH_WORDS] = '{default: '0};
   logic        in_rng, dbg_in, wr_go, hit;
   logic [31:0] lane_m;
   logic [AW-1:0] idx, dbg_idx;
   assign in_rng  = {1'b0, d_mem_addr} < LIMIT;
   assign dbg_in  = {1'b0, dbg_addr} < LIMIT;
   assign idx     = d_mem_addr[AW+1:2];
   assign dbg_idx = dbg_addr[AW+1:2];
   assign lane_m  = {{8{d_mem_wen[3]}}, {8{d_mem_wen[2]}}, {8{d_mem_wen[1]}}, {8{d_mem_wen[0]}}};
   assign wr_go   = d_mem_ready & |d_mem_wen & in_rng;
   assign hit     = d_mem_ready & |d_mem_wen & (d_mem_addr[31:2] == TOHOST_ADDR[31:2]);
   // run_q holds ready low while in reset and for the release edge, so zero-wait mode never completes an access in reset
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      d_mem_ready = 1'b0;
      if (WAIT_STATES == 0) d_mem_ready = d_mem_req & run_q;
      else if (state_q == S_IDLE) begin
         if (d_mem_req) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
         end
      end else if (!d_mem_req) state_d = S_IDLE;
      else if (cnt_q == 4'd0) begin
         d_mem_ready = 1'b1;
         state_d     = S_IDLE;
      end else cnt_d = cnt_q - 4'd1;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
         code_q  <= '0;
         err_q   <= 1'b0;
         wc_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         run_q   <= 1'b1;
         if (hit && !done_q) begin
            done_q <= 1'b1;
            code_q <= d_mem_wdata & lane_m;
         end
         if (d_mem_ready && !in_rng) err_q <= 1'b1;
         if (wr_go && wc_q != '1) wc_q <= wc_q + 32'd1;
      end
   always_ff @(posedge clk)
      if (wr_go)
         for (int k = 0; k < 4; k++)
            if (d_mem_wen[k]) mem[idx][8*k +: 8] <= d_mem_wdata[8*k +: 8];
   assign d_mem_rdata = d_mem_ready ? (in_rng ? mem[idx] : ERR_RDATA) : '0;
   assign dbg_rdata   = dbg_in ? mem[dbg_idx] : ERR_RDATA;
   assign done        = done_q;
   assign done_code   = code_q;
   assign err_oob     = err_q;
   assign wr_count    = wc_q;
endmodule

// File: tb/tb_tb_data_mem_ctrl.sv
// tb_tb_data_mem_ctrl: scoreboard bench for tb_data_mem_ctrl with a zero-wait and a three-wait instance
module tb_tb_data_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0, dbga0 = '0, dbga1 = '0;
   logic [3:0]  wen0 = '0, wen1 = '0;
   logic [31:0] rdata0, rdata1, dbg0, dbg1, code0, code1, wc0, wc1;
   logic        ready0, ready1, done0, done1, oob0, oob1;
   int          total = 0, bad = 0;
   logic [31:0] q0[$], q1[$];
   always #5 clk = ~clk;
   tb_data_mem_ctrl #(.WAIT_STATES(0)) u0 (
      .clk(clk), .rst_n(rst_n), .d_mem_req(req0), .d_mem_addr(addr0), .d_mem_wdata(wdata0),
      .d_mem_wen(wen0), .d_mem_rdata(rdata0), .d_mem_ready(ready0), .dbg_addr(dbga0),
      .dbg_rdata(dbg0), .done(done0), .done_code(code0), .err_oob(oob0), .wr_count(wc0));
   tb_data_mem_ctrl #(.WAIT_STATES(3)) u1 (
      .clk(clk), .rst_n(rst_n), .d_mem_req(req1), .d_mem_addr(addr1), .d_mem_wdata(wdata1),
      .d_mem_wen(wen1), .d_mem_rdata(rdata1), .d_mem_ready(ready1), .dbg_addr(dbga1),
      .dbg_rdata(dbg1), .done(done1), .done_code(code1), .err_oob(oob1), .wr_count(wc1));
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask
   // monitor: every completed read pops the oldest expected value for that instance
   always @(negedge clk) begin
      if (rst_n && req0 && ready0 && wen0 == 4'd0) begin
         if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL rd0_unexpected: got %h want none", rdata0);
         end else chk("rd0", rdata0, q0.pop_front());
      end
      if (rst_n && req1 && ready1 && wen1 == 4'd0) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL rd1_unexpected: got %h want none", rdata1);
         end else chk("rd1", rdata1, q1.pop_front());
      end
   end
   task automatic acc(input int d, input logic [31:0] a, input logic [31:0] w, input logic [3:0] en,
                      input logic [31:0] exp, output int cyc, output logic [31:0] dv);
      logic rdy;
      cyc = 0;
      dv  = '0;
      rdy = 1'b0;
      if (en == 4'd0) begin
         if (d == 0) q0.push_back(exp); else q1.push_back(exp);
      end
      @(posedge clk); #1;
      if (d == 0) begin req0 = 1'b1; addr0 = a; wdata0 = w; wen0 = en; dbga0 = a; end
      else begin req1 = 1'b1; addr1 = a; wdata1 = w; wen1 = en; dbga1 = a; end
      while (!rdy && cyc < 40) begin
         @(negedge clk);
         cyc++;
         rdy = (d == 0) ? ready0 : ready1;
      end
      if (rdy) dv = (d == 0) ? dbg0 : dbg1;
      else begin
         total++; bad++;
         $display("FAIL timeout%0d: got no ready want ready at %h", d, a);
         if (en == 4'd0) begin
            if (d == 0) void'(q0.pop_back()); else void'(q1.pop_back());
         end
      end
      @(posedge clk); #1;
      if (d == 0) req0 = 1'b0; else req1 = 1'b0;
   endtask
   task automatic peek(input int d, input logic [31:0] a, input logic [31:0] exp, input string n);
      if (d == 0) dbga0 = a; else dbga1 = a;
      @(negedge clk);
      chk(n, (d == 0) ? dbg0 : dbg1, exp);
   endtask
   initial begin
      int cyc, seen;
      logic [31:0] dv;
      logic [31:0] res [5] = '{32'd6, 32'd9, 32'd11, 32'd15, 32'd19};
      @(negedge clk);
      chk("rst_ready", {31'd0, ready0}, 0);
      chk("rst_rdata", rdata0, 0);
      chk("rst_done", {31'd0, done0}, 0);
      chk("rst_code", code0, 0);
      chk("rst_oob", {31'd0, oob0}, 0);
      chk("rst_wc", wc0, 0);
      dbga0 = 32'h300;
      #1 chk("mem_zero", dbg0, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      acc(0, 32'h200, 32'h1234_5678, 4'hF, 0, cyc, dv);
      chk("ws0_wr_lat", 32'(cyc), 1);
      acc(0, 32'h200, 0, 4'h0, 32'h1234_5678, cyc, dv);
      chk("ws0_rd_lat", 32'(cyc), 1);
      chk("wc_1", wc0, 1);
      acc(0, 32'h0, 32'hAABB_CCDD, 4'hF, 0, cyc, dv);
      acc(0, 32'h0, 32'h1122_3344, 4'b0101, 0, cyc, dv);
      acc(0, 32'h0, 0, 4'h0, 32'hAA22_CC44, cyc, dv);
      peek(0, 32'h0, 32'hAA22_CC44, "dbg_lanes");
      chk("wc_3", wc0, 3);
      chk("oob_pre", {31'd0, oob0}, 0);
      acc(0, 32'h1000, 0, 4'h0, 32'hDEAD_BEEF, cyc, dv);
      chk("oob_rd", {31'd0, oob0}, 1);
      acc(0, 32'h1000, 32'h5555_5555, 4'hF, 0, cyc, dv);
      chk("oob_wc", wc0, 3);
      peek(0, 32'h0, 32'hAA22_CC44, "oob_intact");
      peek(0, 32'h1000, 32'hDEAD_BEEF, "dbg_oob");
      acc(0, 32'h200, 32'hCAFE_F00D, 4'hF, 0, cyc, dv);
      chk("dbg_old", dv, 32'h1234_5678);
      peek(0, 32'h200, 32'hCAFE_F00D, "dbg_new");
      chk("done_pre", {31'd0, done0}, 0);
      acc(0, 32'hFFC, 32'hFFFF_FF01, 4'b0001, 0, cyc, dv);
      chk("done_set", {31'd0, done0}, 1);
      chk("code_merge", code0, 32'h1);
      acc(0, 32'hFFC, 32'h2, 4'hF, 0, cyc, dv);
      chk("code_sticky", code0, 32'h1);
      chk("wc_6", wc0, 6);
      acc(0, 32'hFFC, 0, 4'h0, 32'h2, cyc, dv);
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst2_done", {31'd0, done0}, 0);
      chk("rst2_wc", wc0, 0);
      chk("rst2_oob", {31'd0, oob0}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      peek(0, 32'h200, 32'hCAFE_F00D, "mem_kept");
      acc(1, 32'h40, 32'h0BAD_F00D, 4'hF, 0, cyc, dv);
      chk("ws3_wr_lat", 32'(cyc), 4);
      acc(1, 32'h40, 0, 4'h0, 32'h0BAD_F00D, cyc, dv);
      chk("ws3_rd_lat", 32'(cyc), 4);
      chk("ws3_wc", wc1, 1);
      @(posedge clk); #1;
      req1 = 1'b1; addr1 = 32'h40; wdata1 = 32'hFFFF_FFFF; wen1 = 4'hF;
      seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (ready1) seen++;
      end
      @(posedge clk); #1 req1 = 1'b0;
      @(negedge clk);
      if (ready1) seen++;
      chk("abort_ready", 32'(seen), 0);
      peek(1, 32'h40, 32'h0BAD_F00D, "abort_mem");
      chk("abort_wc", wc1, 1);
      acc(1, 32'h40, 0, 4'h0, 32'h0BAD_F00D, cyc, dv);
      chk("abort_recover", 32'(cyc), 4);
      @(posedge clk); #1;
      req1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h7777_7777; wen1 = 4'hF;
      @(posedge clk); #1 rst_n = 1'b0;
      #1 chk("rst_mid_ready", {31'd0, ready1}, 0);
      req1 = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      peek(1, 32'h40, 32'h0BAD_F00D, "rst_mid_mem");
      chk("rst_mid_wc", wc1, 0);
      for (int i = 0; i < 5; i++) acc(1, 32'h200 + 32'(4 * i), res[i], 4'hF, 0, cyc, dv);
      chk("prog_not_done", {31'd0, done1}, 0);
      acc(1, 32'hFFC, 32'h1, 4'hF, 0, cyc, dv);
      chk("prog_done", {31'd0, done1}, 1);
      for (int i = 0; i < 5; i++) peek(1, 32'h200 + 32'(4 * i), res[i], $sformatf("prog_%0d", i));
      chk("prog_wc", wc1, 6);
      chk("q_empty", 32'(q0.size() + q1.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
